mips_bus_bridge: RTL and testbench

Multi-cycle bridge between the Harvard MIPS core and a single Avalon-style memory bus with `waitrequest`. Each instruction is sequenced through FETCH, optional DATA and COMMIT phases. The core's split instruction and data ports are serialised onto one bus. A one-cycle `clock_enable` pulse commits the instruction's architectural updates. The bridge sits between the core's memory ports and the system bus; the core's `clock_enable` input is driven only by this block.

---
 rtl/mips_bus_bridge.sv | 149 ++++++++++++++
 tb/tb_mips_bus_bridge.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_bus_bridge.sv
// mips_bus_bridge: serialises the MIPS core's instruction and data ports onto
// one Avalon-style bus with waitrequest. Each instruction is sequenced through
// FETCH -> DATA -> COMMIT. COMMIT issues a single clock_enable pulse to the core.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_core_active           core running flag, sampled in COMMIT only
//   i_instr_address         core fetch address
//   o_instr_readdata        last fetched word (registered)
//   i_data_address          core load/store address
//   i_data_writedata        core store data
//   i_data_read/i_data_write core load/store requests
//   o_data_readdata         last loaded word (registered)
//   o_clock_enable          one-cycle commit pulse (registered)
//   o_address, o_read, o_write, o_writedata, o_byteenable  bus master side
//   i_readdata, i_waitrequest                              bus responses
module mips_bus_bridge (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_core_active,
    input  logic [31:0] i_instr_address,
    output logic [31:0] o_instr_readdata,
    input  logic [31:0] i_data_address,
    input  logic [31:0] i_data_writedata,
    input  logic        i_data_read,
    input  logic        i_data_write,
    output logic [31:0] o_data_readdata,
    output logic        o_clock_enable,
    output logic [31:0] o_address,
    output logic        o_read,
    output logic        o_write,
    output logic [31:0] o_writedata,
    output logic [3:0]  o_byteenable,
    input  logic [31:0] i_readdata,
    input  logic        i_waitrequest
);

    localparam logic [3:0] BYTEENABLE_ALL = 4'b1111;

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DATA   = 2'd1,
        S_COMMIT = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_instr_readdata;
    logic [31:0] r_data_readdata;
    logic        r_clock_enable;

    logic        w_read;
    logic        w_write;
    logic [31:0] w_address;
    logic [31:0] w_writedata;
    logic [3:0]  w_byteenable;

    // Bus strobes decoded from state and core inputs. Gating with i_rst_n makes
    // the strobes drop immediately when reset is asserted, without a clock.
    always_comb begin
        w_read       = 1'b0;
        w_write      = 1'b0;
        w_address    = 32'd0;
        w_writedata  = 32'd0;
        w_byteenable = 4'd0;
        if (i_rst_n) begin
            case (r_state)
                S_FETCH: begin
                    w_read    = 1'b1;
                    w_address = {i_instr_address[31:2], 2'b00};
                end
                S_DATA: begin
                    // A store wins over a simultaneous load.
                    if (i_data_write) begin
                        w_write     = 1'b1;
                        w_address   = {i_data_address[31:2], 2'b00};
                        w_writedata = i_data_writedata;
                    end else if (i_data_read) begin
                        w_read    = 1'b1;
                        w_address = {i_data_address[31:2], 2'b00};
                    end
                end
                default: begin
                end
            endcase
            if (w_read || w_write) begin
                w_byteenable = BYTEENABLE_ALL;
            end
        end
    end

    // Sequencer with registered read data and commit pulse. The pulse register
    // is set on the edge entering COMMIT so it is high exactly during COMMIT.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state          <= S_FETCH;
            r_instr_readdata <= 32'd0;
            r_data_readdata  <= 32'd0;
            r_clock_enable   <= 1'b0;
        end else begin
            r_clock_enable <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (!i_waitrequest) begin
                        r_instr_readdata <= i_readdata;
                        r_state          <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (i_data_write) begin
                        if (!i_waitrequest) begin
                            r_state        <= S_COMMIT;
                            r_clock_enable <= 1'b1;
                        end
                    end else if (i_data_read) begin
                        if (!i_waitrequest) begin
                            r_data_readdata <= i_readdata;
                            r_state         <= S_COMMIT;
                            r_clock_enable  <= 1'b1;
                        end
                    end else begin
                        // No data access: one idle cycle, then commit.
                        r_state        <= S_COMMIT;
                        r_clock_enable <= 1'b1;
                    end
                end
                S_COMMIT: begin
                    r_state <= i_core_active ? S_FETCH : S_HALT;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    assign o_instr_readdata = r_instr_readdata;
    assign o_data_readdata  = r_data_readdata;
    assign o_clock_enable   = r_clock_enable;
    assign o_address        = w_address;
    assign o_read           = w_read;
    assign o_write          = w_write;
    assign o_writedata      = w_writedata;
    assign o_byteenable     = w_byteenable;

endmodule

// File: tb/tb_mips_bus_bridge.sv
// Bench for mips_bus_bridge. Each directed instruction is expanded into the
// per-cycle bus trace it must produce (wait states included); one compare
// process checks the DUT against that trace every cycle.
module tb_mips_bus_bridge;

    logic        clk;
    logic        rst_n;
    logic        core_active;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic [31:0] data_address;
    logic [31:0] data_writedata;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_readdata;
    logic        clock_enable;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        waitrequest;

    mips_bus_bridge dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_core_active    (core_active),
        .i_instr_address  (instr_address),
        .o_instr_readdata (instr_readdata),
        .i_data_address   (data_address),
        .i_data_writedata (data_writedata),
        .i_data_read      (data_read),
        .i_data_write     (data_write),
        .o_data_readdata  (data_readdata),
        .o_clock_enable   (clock_enable),
        .o_address        (address),
        .o_read           (read),
        .o_write          (write),
        .o_writedata      (writedata),
        .o_byteenable     (byteenable),
        .i_readdata       (readdata),
        .i_waitrequest    (waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bus cycle: inputs to drive and outputs that must be observed.
    typedef struct {
        logic [31:0] ia, da, dwd, rdata;
        logic        dr, dw, act, wr;
        logic        e_read, e_write, e_ce;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_be;
        logic        lat_i, lat_d;
    } ent_t;

    ent_t        q[$];
    ent_t        cur;
    logic        cur_valid = 1'b0;
    logic [31:0] exp_instr = 32'd0;
    logic [31:0] exp_data  = 32'd0;
    int          checks = 0;
    int          errors = 0;
    int          slot = 0;
    int          ce_slot = 0;
    int          ce_count = 0;
    int          ce_before;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ent_t base(input logic [31:0] ia, da, dwd, input logic dr, dw, act);
        ent_t e;
        e = '{default: '0};
        e.ia = ia; e.da = da; e.dwd = dwd; e.dr = dr; e.dw = dw; e.act = act;
        e.rdata = 32'hBAD0_0000 ^ ia;  // junk that must never be latched
        return e;
    endfunction

    // Expand one instruction into its expected bus trace.
    function automatic void add_instr(input logic [31:0] ia, iword, da, dwd, ldata,
                                      input logic dr, dw, act, input int wf, wd);
        ent_t e;
        for (int k = 0; k <= wf; k++) begin
            e = base(ia, da, dwd, dr, dw, act);
            e.e_read = 1'b1; e.e_addr = ia & 32'hFFFF_FFFC; e.e_be = 4'hF;
            e.wr = (k < wf);
            if (k == wf) begin e.rdata = iword; e.lat_i = 1'b1; end
            q.push_back(e);
        end
        if (dw || dr) begin
            for (int k = 0; k <= wd; k++) begin
                e = base(ia, da, dwd, dr, dw, act);
                e.e_addr = da & 32'hFFFF_FFFC; e.e_be = 4'hF;
                if (dw) begin
                    e.e_write = 1'b1; e.e_wdata = dwd;
                end else begin
                    e.e_read = 1'b1;
                end
                e.wr = (k < wd);
                if (k == wd && !dw) begin e.rdata = ldata; e.lat_d = 1'b1; end
                q.push_back(e);
            end
        end else begin
            q.push_back(base(ia, da, dwd, dr, dw, act));
        end
        e = base(ia, da, dwd, dr, dw, act);
        e.e_ce = 1'b1;
        q.push_back(e);
    endfunction

    function automatic void add_idle(input int n);
        for (int k = 0; k < n; k++) q.push_back(base(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
    endfunction

    task automatic drive(input ent_t e);
        instr_address = e.ia; data_address = e.da; data_writedata = e.dwd;
        data_read = e.dr; data_write = e.dw; core_active = e.act;
        waitrequest = e.wr; readdata = e.rdata;
        cur = e; cur_valid = 1'b1;
    endtask

    // Play the first n entries of the trace, one per clock, starting at posedge+1.
    task automatic run_trace(input int n);
        int lim;
        lim = (n < q.size()) ? n : q.size();
        for (int i = 0; i < lim; i++) begin
            slot = i + 1;
            drive(q[i]);
            @(posedge clk);
            if (q[i].lat_i) exp_instr = q[i].rdata;
            if (q[i].lat_d) exp_data  = q[i].rdata;
            #1;
        end
        cur_valid = 1'b0;
    endtask

    // Cycle-by-cycle comparison against the expected trace.
    always @(negedge clk) begin
        if (cur_valid) begin
            chk("read",           32'(read),         32'(cur.e_read));
            chk("write",          32'(write),        32'(cur.e_write));
            chk("address",        address,           cur.e_addr);
            chk("writedata",      writedata,         cur.e_wdata);
            chk("byteenable",     32'(byteenable),   32'(cur.e_be));
            chk("clock_enable",   32'(clock_enable), 32'(cur.e_ce));
            chk("instr_readdata", instr_readdata,    exp_instr);
            chk("data_readdata",  data_readdata,     exp_data);
            if (clock_enable) begin
                ce_count++;
                ce_slot = slot;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; core_active = 1'b1; instr_address = 32'h0; data_address = 32'h0;
        data_writedata = 32'h0; data_read = 1'b0; data_write = 1'b0;
        readdata = 32'h0; waitrequest = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset read",    32'(read),         32'd0);
        chk("reset address", address,           32'd0);
        chk("reset be",      32'(byteenable),   32'd0);
        chk("reset ce",      32'(clock_enable), 32'd0);
        chk("reset instr",   instr_readdata,    32'd0);
        rst_n = 1'b1;

        // Fetch, no data: commit in cycle 3, next fetch in cycle 4.
        q.delete(); ce_slot = 0;
        add_instr(32'hBFC0_0000, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 0, 0);
        run_trace(99);
        chk("pin fetch word", instr_readdata, 32'h1234_5678);
        chk("pin fetch ce slot", 32'(ce_slot), 32'd3);
        #1;
        chk("pin next fetch read", 32'(read), 32'd1);

        // Load with two wait states in DATA: commit in cycle 5.
        q.delete(); ce_slot = 0;
        add_instr(32'hBFC0_0004, 32'h8C00_1003, 32'h0000_1003, 32'h0, 32'hCAFE_F00D,
                  1'b1, 1'b0, 1'b1, 0, 2);
        run_trace(99);
        chk("pin load data", data_readdata, 32'hCAFE_F00D);
        chk("pin load ce slot", 32'(ce_slot), 32'd5);

        // Store, with one wait state during FETCH.
        q.delete(); ce_before = ce_count;
        add_instr(32'hBFC0_0009, 32'hAC00_2000, 32'h0000_2000, 32'hDEAD_BEEF, 32'h0,
                  1'b0, 1'b1, 1'b1, 1, 0);
        run_trace(99);
        chk("pin store ce count", 32'(ce_count - ce_before), 32'd1);

        // Conflicting requests: write only, load register untouched.
        q.delete();
        add_instr(32'hBFC0_000C, 32'h0BAD_CAFE, 32'h0000_3006, 32'h5555_AAAA, 32'h0,
                  1'b1, 1'b1, 1'b1, 0, 1);
        run_trace(99);
        chk("pin conflict data", data_readdata, 32'hCAFE_F00D);

        // Halt: one last commit, then 20 quiet cycles.
        q.delete(); ce_before = ce_count;
        add_instr(32'hBFC0_0010, 32'h0000_000D, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 0, 0);
        add_idle(20);
        run_trace(99);
        chk("pin halt ce count", 32'(ce_count - ce_before), 32'd1);

        // Async reset during a stalled fetch.
        rst_n = 1'b0;
        exp_instr = 32'd0; exp_data = 32'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        q.delete();
        add_instr(32'hBFC0_0020, 32'h1111_2222, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 3, 0);
        run_trace(2);
        drive(q[2]);
        @(negedge clk); #1;
        rst_n = 1'b0;
        cur_valid = 1'b0;
        #1;
        chk("abort read",    32'(read),         32'd0);
        chk("abort address", address,           32'd0);
        chk("abort instr",   instr_readdata,    32'd0);
        chk("abort ce",      32'(clock_enable), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        q.delete(); ce_slot = 0;
        add_instr(32'hBFC0_0020, 32'h1111_2222, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 0, 0);
        run_trace(99);
        chk("pin restart ce slot", 32'(ce_slot), 32'd3);
        chk("pin restart word", instr_readdata, 32'h1111_2222);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
